// File: rtl/rvga_mem_arbiter_pkg.sv
// Shared types for the imem/dmem backing-memory arbiter: bus word, FSM states,
// client identifiers and the word-alignment helper.
package rvga_mem_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] rvga_word;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } rvga_mem_state_e;

  typedef enum logic {
    CLIENT_I,
    CLIENT_D
  } rvga_mem_client_e;

  function automatic rvga_word word_align(input rvga_word addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rvga_mem_arbiter_if.sv
// Backing-memory bus between the arbiter (master) and the memory (slave).
interface rvga_mem_arbiter_if;
  import rvga_mem_arbiter_pkg::*;

  logic     mem_v_o;
  logic     mem_w_v_o;
  rvga_word mem_addr_o;
  rvga_word mem_data_o;
  logic     mem_ready_i;
  logic     mem_resp_v_i;
  rvga_word mem_data_i;

  modport master (
    output mem_v_o, mem_w_v_o, mem_addr_o, mem_data_o,
    input  mem_ready_i, mem_resp_v_i, mem_data_i
  );

  modport slave (
    input  mem_v_o, mem_w_v_o, mem_addr_o, mem_data_o,
    output mem_ready_i, mem_resp_v_i, mem_data_i
  );

endinterface

// File: rtl/rvga_mem_arbiter_pick.sv
// Combinational grant selector. Fixed dmem priority by default; with
// RVGA_MEM_ARB_RR_EN defined, simultaneous requests alternate on last grant.
module rvga_mem_arb_pick
  import rvga_mem_arbiter_pkg::*;
(
  input  logic             imem_req_i,
  input  logic             dmem_req_i,
  input  rvga_mem_client_e last_i,
  output rvga_mem_client_e grant_o
);

  always_comb begin
    grant_o = CLIENT_I;
`ifdef RVGA_MEM_ARB_RR_EN
    if (imem_req_i && dmem_req_i) begin
      grant_o = (last_i == CLIENT_D) ? CLIENT_I : CLIENT_D;
    end else if (dmem_req_i) begin
      grant_o = CLIENT_D;
    end
`else
    if (dmem_req_i) begin
      grant_o = CLIENT_D;
    end
`endif
  end

`ifndef RVGA_MEM_ARB_RR_EN
  logic unused_pick;
  assign unused_pick = imem_req_i ^ (last_i == CLIENT_D);
`endif

endmodule

// File: rtl/rvga_mem_arbiter.sv
// Single-outstanding arbiter merging imem and dmem onto one memory bus.
// Optional round-robin grant under macro RVGA_MEM_ARB_RR_EN.
module rvga_mem_arbiter
  import rvga_mem_arbiter_pkg::*;
#(
  parameter int WORD_ALIGN_V = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     imem_v_i,
  input  rvga_word imem_addr_i,
  output rvga_word imem_data_o,
  output logic     imem_resp_v_o,
  input  logic     dmem_r_v_i,
  input  logic     dmem_w_v_i,
  input  rvga_word dmem_addr_i,
  input  rvga_word dmem_data_i,
  output rvga_word dmem_data_o,
  output logic     dmem_resp_v_o,
  rvga_mem_arbiter_if.master mem
);

  rvga_mem_state_e  state_q, state_d;
  rvga_mem_client_e grant_q, grant_d;
  rvga_word         addr_q, addr_d;
  rvga_word         wdata_q, wdata_d;
  rvga_word         rdata_q, rdata_d;
  logic             w_q, w_d;
  logic             dmem_req;
  rvga_mem_client_e pick_grant;
  rvga_mem_client_e pick_last;

  assign dmem_req = dmem_r_v_i | dmem_w_v_i;

`ifdef RVGA_MEM_ARB_RR_EN
  rvga_mem_client_e last_q, last_d;
  assign pick_last = last_q;
`else
  assign pick_last = CLIENT_I;
`endif

  rvga_mem_arb_pick u_pick (
    .imem_req_i (imem_v_i),
    .dmem_req_i (dmem_req),
    .last_i     (pick_last),
    .grant_o    (pick_grant)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= CLIENT_I;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      w_q     <= 1'b0;
`ifdef RVGA_MEM_ARB_RR_EN
      last_q  <= CLIENT_I;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      w_q     <= w_d;
`ifdef RVGA_MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Requests are only sampled in IDLE; a spurious mem_resp_v_i elsewhere is ignored.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    w_d     = w_q;
`ifdef RVGA_MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (dmem_req || imem_v_i) begin
          grant_d = pick_grant;
`ifdef RVGA_MEM_ARB_RR_EN
          last_d  = pick_grant;
`endif
          if (pick_grant == CLIENT_D) begin
            addr_d  = dmem_addr_i;
            wdata_d = dmem_data_i;
            w_d     = dmem_w_v_i;
          end else begin
            addr_d  = imem_addr_i;
            wdata_d = '0;
            w_d     = 1'b0;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem.mem_ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem.mem_resp_v_i) begin
          rdata_d = mem.mem_data_i;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem.mem_v_o    = (state_q == ISSUE);
  assign mem.mem_w_v_o  = (state_q == ISSUE) && w_q;
  assign mem.mem_addr_o = (WORD_ALIGN_V != 0) ? word_align(addr_q) : addr_q;
  assign mem.mem_data_o = wdata_q;

  assign imem_resp_v_o = (state_q == RESP) && (grant_q == CLIENT_I);
  assign dmem_resp_v_o = (state_q == RESP) && (grant_q == CLIENT_D);
  assign imem_data_o   = imem_resp_v_o ? rdata_q : '0;
  assign dmem_data_o   = (dmem_resp_v_o && !w_q) ? rdata_q : '0;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Directed self-checking bench for rvga_mem_arbiter (default WORD_ALIGN_V = 1).
module tb_rvga_mem_arbiter;
  import rvga_mem_arbiter_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     imem_v;
  rvga_word imem_addr;
  rvga_word imem_data;
  logic     imem_resp_v;
  logic     dmem_r_v;
  logic     dmem_w_v;
  rvga_word dmem_addr;
  rvga_word dmem_wdata;
  rvga_word dmem_rdata;
  logic     dmem_resp_v;

  int checks = 0;
  int errors = 0;

  rvga_mem_arbiter_if mif ();

  rvga_mem_arbiter dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_v_i      (imem_v),
    .imem_addr_i   (imem_addr),
    .imem_data_o   (imem_data),
    .imem_resp_v_o (imem_resp_v),
    .dmem_r_v_i    (dmem_r_v),
    .dmem_w_v_i    (dmem_w_v),
    .dmem_addr_i   (dmem_addr),
    .dmem_data_i   (dmem_wdata),
    .dmem_data_o   (dmem_rdata),
    .dmem_resp_v_o (dmem_resp_v),
    .mem           (mif.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [133:0] obs;
    rst = 1'b1;
    imem_v = 1'b0; imem_addr = '0;
    dmem_r_v = 1'b0; dmem_w_v = 1'b0; dmem_addr = '0; dmem_wdata = '0;
    mif.mem_ready_i = 1'b0; mif.mem_resp_v_i = 1'b0; mif.mem_data_i = '0;
    step(); step();
    obs = {mif.mem_v_o, mif.mem_w_v_o, mif.mem_addr_o, mif.mem_data_o,
           imem_resp_v, dmem_resp_v, imem_data, dmem_rdata};
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", obs);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({mif.mem_v_o, imem_resp_v, dmem_resp_v} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset got %b exp 000", {mif.mem_v_o, imem_resp_v, dmem_resp_v});
    end
  endtask

  task automatic test_single_imem();
    imem_v = 1'b1; imem_addr = 32'h0000_0040; mif.mem_ready_i = 1'b1;
    step();
    checks++;
    if ({mif.mem_v_o, mif.mem_w_v_o, mif.mem_addr_o} !== {2'b10, 32'h40}) begin
      errors++; $display("FAIL imem_issue got v=%b w=%b a=%h exp v=1 w=0 a=40", mif.mem_v_o, mif.mem_w_v_o, mif.mem_addr_o);
    end
    step();
    mif.mem_resp_v_i = 1'b1; mif.mem_data_i = 32'h0000_0013;
    checks++;
    if (imem_resp_v !== 1'b0) begin
      errors++; $display("FAIL imem_early_strobe got %b exp 0", imem_resp_v);
    end
    step();
    mif.mem_resp_v_i = 1'b0;
    checks++;
    if ({imem_resp_v, imem_data, dmem_resp_v} !== {1'b1, 32'h13, 1'b0}) begin
      errors++; $display("FAIL imem_resp got v=%b d=%h dv=%b exp v=1 d=13 dv=0", imem_resp_v, imem_data, dmem_resp_v);
    end
    imem_v = 1'b0;
    step();
    checks++;
    if ({imem_resp_v, imem_data} !== 33'h0) begin
      errors++; $display("FAIL imem_strobe_one_cycle got v=%b d=%h exp 0", imem_resp_v, imem_data);
    end
  endtask

  task automatic test_dmem_write_vs_imem();
    dmem_w_v = 1'b1; dmem_addr = 32'h100; dmem_wdata = 32'hDEAD_BEEF;
    imem_v = 1'b1; imem_addr = 32'h44; mif.mem_ready_i = 1'b1;
    step();
    checks++;
    if ({mif.mem_v_o, mif.mem_w_v_o, mif.mem_addr_o, mif.mem_data_o} !== {2'b11, 32'h100, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL dwrite_issue got v=%b w=%b a=%h d=%h exp 1 1 100 deadbeef",
                         mif.mem_v_o, mif.mem_w_v_o, mif.mem_addr_o, mif.mem_data_o);
    end
    step();
    mif.mem_resp_v_i = 1'b1; mif.mem_data_i = 32'h5555_5555;
    step();
    mif.mem_resp_v_i = 1'b0;
    checks++;
    if ({dmem_resp_v, dmem_rdata, imem_resp_v, imem_data} !== {1'b1, 32'h0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL dwrite_ack got dv=%b dd=%h iv=%b id=%h exp 1 0 0 0", dmem_resp_v, dmem_rdata, imem_resp_v, imem_data);
    end
    dmem_w_v = 1'b0;
    step();
    step();
    checks++;
    if ({mif.mem_v_o, mif.mem_w_v_o, mif.mem_addr_o} !== {2'b10, 32'h44}) begin
      errors++; $display("FAIL imem_after_dwrite got v=%b w=%b a=%h exp 1 0 44", mif.mem_v_o, mif.mem_w_v_o, mif.mem_addr_o);
    end
    step();
    mif.mem_resp_v_i = 1'b1; mif.mem_data_i = 32'h0000_0077;
    step();
    mif.mem_resp_v_i = 1'b0;
    checks++;
    if ({imem_resp_v, imem_data} !== {1'b1, 32'h77}) begin
      errors++; $display("FAIL imem_after_dwrite_resp got v=%b d=%h exp 1 77", imem_resp_v, imem_data);
    end
    imem_v = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    dmem_r_v = 1'b1; dmem_addr = 32'h80; dmem_wdata = 32'h1234; mif.mem_ready_i = 1'b0;
    step();
    dmem_r_v = 1'b0; dmem_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mif.mem_v_o, mif.mem_addr_o, mif.mem_data_o} !== {1'b1, 32'h80, 32'h1234}) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b a=%h d=%h exp 1 80 1234", i, mif.mem_v_o, mif.mem_addr_o, mif.mem_data_o);
      end
      step();
    end
    mif.mem_ready_i = 1'b1;
    checks++;
    if (mif.mem_v_o !== 1'b1) begin
      errors++; $display("FAIL bp_accept_cycle got %b exp 1", mif.mem_v_o);
    end
    step();
    mif.mem_resp_v_i = 1'b1; mif.mem_data_i = 32'h0000_ABCD;
    checks++;
    if ({mif.mem_v_o, dmem_resp_v} !== 2'b00) begin
      errors++; $display("FAIL bp_wait got %b exp 00", {mif.mem_v_o, dmem_resp_v});
    end
    step();
    mif.mem_resp_v_i = 1'b0;
    checks++;
    if ({dmem_resp_v, dmem_rdata} !== {1'b1, 32'hABCD}) begin
      errors++; $display("FAIL bp_resp got v=%b d=%h exp 1 abcd", dmem_resp_v, dmem_rdata);
    end
    step();
  endtask

  task automatic test_spurious_and_reset();
    mif.mem_resp_v_i = 1'b1; mif.mem_data_i = 32'hBAD0_BAD0;
    step();
    mif.mem_resp_v_i = 1'b0;
    checks++;
    if ({mif.mem_v_o, imem_resp_v, dmem_resp_v} !== 3'b000) begin
      errors++; $display("FAIL spurious_idle got %b exp 000", {mif.mem_v_o, imem_resp_v, dmem_resp_v});
    end
    imem_v = 1'b1; imem_addr = 32'h60; mif.mem_ready_i = 1'b1;
    step();
    imem_v = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mif.mem_resp_v_i = 1'b1; mif.mem_data_i = 32'h0000_0BAD;
    checks++;
    if ({mif.mem_v_o, mif.mem_addr_o, imem_resp_v} !== {1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL midop_reset_clear got v=%b a=%h iv=%b exp 0 0 0", mif.mem_v_o, mif.mem_addr_o, imem_resp_v);
    end
    step();
    mif.mem_resp_v_i = 1'b0;
    checks++;
    if ({imem_resp_v, dmem_resp_v, mif.mem_v_o} !== 3'b000) begin
      errors++; $display("FAIL late_resp_ignored got %b exp 000", {imem_resp_v, dmem_resp_v, mif.mem_v_o});
    end
    imem_v = 1'b1; imem_addr = 32'h64;
    step();
    imem_v = 1'b0;
    checks++;
    if ({mif.mem_v_o, mif.mem_addr_o} !== {1'b1, 32'h64}) begin
      errors++; $display("FAIL idle_after_reset_issue got v=%b a=%h exp 1 64", mif.mem_v_o, mif.mem_addr_o);
    end
    step();
    mif.mem_resp_v_i = 1'b1; mif.mem_data_i = 32'h1;
    step();
    mif.mem_resp_v_i = 1'b0;
    step();
  endtask

  task automatic test_unaligned();
    dmem_r_v = 1'b1; dmem_addr = 32'h103; mif.mem_ready_i = 1'b1;
    step();
    dmem_r_v = 1'b0;
    checks++;
    if (mif.mem_addr_o !== 32'h100) begin
      errors++; $display("FAIL unaligned_issue got %h exp 100", mif.mem_addr_o);
    end
    step();
    checks++;
    if (mif.mem_addr_o !== 32'h100) begin
      errors++; $display("FAIL unaligned_wait got %h exp 100", mif.mem_addr_o);
    end
    mif.mem_resp_v_i = 1'b1; mif.mem_data_i = 32'h2;
    step();
    mif.mem_resp_v_i = 1'b0;
    step();
  endtask

  task automatic test_arbitration();
    rvga_mem_client_e exp_g, got_g;
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    dmem_r_v = 1'b1; dmem_addr = 32'h200; imem_v = 1'b1; imem_addr = 32'h300;
    mif.mem_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (mif.mem_v_o !== 1'b1 && n < 10) begin
        step();
        n++;
      end
      if (mif.mem_v_o !== 1'b1) begin
        checks++; errors++;
        $display("FAIL arb_timeout[%0d] got no issue exp issue", k);
        break;
      end
`ifdef RVGA_MEM_ARB_RR_EN
      exp_g = (k % 2 == 0) ? CLIENT_D : CLIENT_I;
`else
      exp_g = CLIENT_D;
`endif
      got_g = (mif.mem_addr_o == 32'h200) ? CLIENT_D : CLIENT_I;
      checks++;
      if (got_g !== exp_g) begin
        errors++; $display("FAIL arb_grant[%0d] got %s exp %s", k, got_g.name(), exp_g.name());
      end
      step();
      mif.mem_resp_v_i = 1'b1; mif.mem_data_i = 32'(k);
      step();
      mif.mem_resp_v_i = 1'b0;
      checks++;
      if ({dmem_resp_v, imem_resp_v} !== ((exp_g == CLIENT_D) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL arb_strobe[%0d] got %b exp %b", k, {dmem_resp_v, imem_resp_v},
                           (exp_g == CLIENT_D) ? 2'b10 : 2'b01);
      end
    end
    dmem_r_v = 1'b0; imem_v = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_imem();
    test_dmem_write_vs_imem();
    test_backpressure();
    test_spurious_and_reset();
    test_unaligned();
    test_arbitration();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvga_mem_arbiter.md
Name: rvga_mem_arbiter

Overview:
- Sits directly downstream of the core top level.
- Merges the core's instruction-fetch port (imem) and data port (dmem) onto one shared word-wide backing-memory bus.
- Supports one outstanding transaction and returns each response to the client that issued it.
- Provides the imem_resp_v and dmem_resp_v strobes consumed by the hazard unit.

Parameters:
- WORD_ALIGN_V, default 1: when 1, mem_addr_o[1:0] is forced to 2'b00; when 0, the address passes through unmodified.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- imem_v_i  in  1  instruction read request; tied to 1 at core top.
- imem_addr_i  in  rvga_word  fetch address; held by the core until imem_resp_v_o.
- imem_data_o  out  rvga_word  fetched instruction; valid only with imem_resp_v_o.
- imem_resp_v_o  out  1  one-cycle response strobe to the fetch port.
- dmem_r_v_i  in  1  data read request.
- dmem_w_v_i  in  1  data write request.
- dmem_addr_i  in  rvga_word  data address.
- dmem_data_i  in  rvga_word  store data.
- dmem_data_o  out  rvga_word  load data; valid only with dmem_resp_v_o.
- dmem_resp_v_o  out  1  one-cycle strobe; acknowledges both reads and writes.
- mem_v_o  out  1  backing-memory request valid.
- mem_w_v_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  rvga_word  backing-memory address.
- mem_data_o  out  rvga_word  write data.
- mem_ready_i  in  1  memory accepts the request in a cycle where mem_v_o && mem_ready_i.
- mem_resp_v_i  in  1  memory response strobe (read data or write ack).
- mem_data_i  in  rvga_word  read data from memory.

Behaviour:
- Reset values: FSM in IDLE; all *_v_o = 0; all data and address outputs = 0; grant register = imem; last-grant register = imem.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If dmem_r_v_i or dmem_w_v_i is set: latch the dmem address, data and write flag (w_v wins if both r_v and w_v are high); grant = dmem; go to ISSUE.
  - Else if imem_v_i: latch imem_addr_i; grant = imem; go to ISSUE.
  - Else stay in IDLE.
- ISSUE: mem_v_o = 1 and all mem_* outputs come from the latched registers, stable while mem_ready_i = 0. On mem_ready_i, go to WAIT.
- WAIT: on mem_resp_v_i, latch mem_data_i and go to RESP.
- RESP: assert the granted client's resp_v_o for exactly one cycle, with data_o = the latched value; go to IDLE.
  - For a write, dmem_data_o = 0.
  - The non-granted client's outputs stay 0.
- Latency: request sampled in IDLE at cycle t, ISSUE at t+1. With mem_ready_i high and the response in the cycle after acceptance, the response arrives at t+2 and resp_v_o is asserted at t+3. Minimum request-to-response is 3 cycles.
- Back-to-back: IDLE always follows RESP. The client therefore presents its next address in the cycle after the strobe, and a stale held request is never re-issued.
- mem_resp_v_i in IDLE, ISSUE or RESP is a protocol violation and is ignored; no state change.
- Requests change only in IDLE. A client request dropped while another client is granted is simply not serviced.
- Reset mid-transaction: return to IDLE next cycle with outputs cleared. Any late mem_resp_v_i is ignored per the rule above.
- Fixed priority: dmem beats imem. The pipeline stalls on dmem, so imem cannot starve indefinitely.

Optional Feature:
- Macro: RVGA_MEM_ARB_RR_EN.
- Defined: when both clients request in IDLE, grant the client opposite to the last-grant register; last-grant updates on every grant. A single requester is always granted.
- Undefined: fixed dmem priority; the last-grant register is not synthesized.

Decomposition:
- rvga_types gains:
  - rvga_mem_state_e enum: IDLE, ISSUE, WAIT, RESP.
  - rvga_mem_client_e enum: CLIENT_I, CLIENT_D.
- One natural sub-module: rvga_mem_arb_pick, a combinational grant selector that takes the request bits and last-grant and returns a rvga_mem_client_e. It holds the RR_EN variation.
- FSM and datapath registers stay in rvga_mem_arbiter.

Test Plan:
- Single imem read:
  - Stimulus: imem_addr_i = 0x0000_0040, mem_ready_i = 1, memory returns 0x0000_0013 one cycle after accept.
  - Response: mem_addr_o = 0x40 with mem_w_v_o = 0 at t+1; imem_resp_v_o = 1 with imem_data_o = 0x13 at t+3 only.
- dmem write vs. pending imem:
  - Stimulus: both request in the same IDLE cycle; dmem_w_v_i = 1, addr = 0x100, data = 0xDEAD_BEEF.
  - Response: first issue is mem_w_v_o = 1, addr 0x100, data 0xDEADBEEF; dmem_resp_v_o pulses; the imem read issues next.
- Backpressure:
  - Stimulus: mem_ready_i low for 5 cycles during ISSUE.
  - Response: mem_v_o, mem_addr_o and mem_data_o stay constant for all 5 cycles; the response strobe is delayed by exactly 5 cycles.
- Spurious response / mid-op reset:
  - Stimulus: mem_resp_v_i pulsed in IDLE; separately, rst_i in WAIT followed by a late mem_resp_v_i.
  - Response: no resp_v_o in either case; the FSM ends in IDLE.
- Unaligned address:
  - Stimulus: dmem read at 0x103.
  - Response: mem_addr_o = 0x100 with WAIT under WORD_ALIGN_V = 1; 0x103 under WORD_ALIGN_V = 0.
- RR_EN defined:
  - Stimulus: both clients request continuously.
  - Response: grants alternate D, I, D, I; with the macro undefined, dmem is granted every time.
